// File: rtl/de_issue_pkg.sv
// Shared opcode constants, micro-op kinds and per-kind sequence shape for the decode issue controller.
package de_issue_pkg;

  localparam logic [4:0] OP_CALL = 5'h18;
  localparam logic [4:0] OP_RET  = 5'h19;
  localparam logic [4:0] OP_RTI  = 5'h1A;

  typedef enum logic [2:0] {
    K_NORM = 3'd0,
    K_CALL = 3'd1,
    K_RET  = 3'd2,
    K_RTI  = 3'd3,
    K_INT  = 3'd4
  } kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEQ  = 1'b1
  } state_e;

  // Index of the final slot of each kind's stack sequence.
  function automatic logic [1:0] last_slot(input logic [2:0] kind);
    case (kind)
      K_CALL, K_RET: last_slot = 2'd1;
      K_RTI, K_INT:  last_slot = 2'd2;
      default:       last_slot = 2'd0;
    endcase
  endfunction

  // CALL and interrupt entry save state; RET and RTI restore it.
  function automatic logic kind_push(input logic [2:0] kind);
    case (kind)
      K_CALL, K_INT: kind_push = 1'b1;
      default:       kind_push = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/de_seq_len.sv
// Opcode classifier: maps a fetched opcode to its micro-op kind, last slot index and push/pop direction.
import de_issue_pkg::*;

module de_seq_len (
  input  logic [4:0] opcode_i,
  output logic [2:0] kind_o,
  output logic [1:0] last_o,
  output logic       push_o
);

  logic [2:0] kind;

  always_comb begin
    kind = K_NORM;
    case (opcode_i)
      OP_CALL: kind = K_CALL;
      OP_RET:  kind = K_RET;
      OP_RTI:  kind = K_RTI;
      default: kind = K_NORM;
    endcase
    kind_o = kind;
    last_o = last_slot(kind);
    push_o = kind_push(kind);
  end

endmodule

// File: rtl/de_issue_ctrl.sv
// Decode issue controller: expands CALL/RET/RTI (and interrupts) into push/pop slot sequences.
// Interrupt entry sequences are generated only when DE_ISSUE_IRQ_EN is defined.
import de_issue_pkg::*;

module de_issue_ctrl #(
  parameter int IW  = 16,
  parameter int PCW = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  in_instr,
  input  logic [PCW-1:0] in_pc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IW-1:0]  out_instr,
  output logic [PCW-1:0] out_pc,
  output logic [2:0]     out_kind,
  output logic [1:0]     out_slot,
  output logic           out_push,
  input  logic           flush,
  input  logic           irq_req,
  output logic           irq_ack
);

  state_e         state_q;
  logic           out_valid_q;
  logic [IW-1:0]  out_instr_q;
  logic [PCW-1:0] out_pc_q;
  logic [2:0]     out_kind_q;
  logic [1:0]     out_slot_q;
  logic           out_push_q;
  logic           irq_ack_q;

  logic [2:0] dec_kind;
  logic [1:0] dec_last;
  logic       dec_push;
  logic       advance;
  logic       irq_take;

  de_seq_len u_seq_len (
    .opcode_i (in_instr[IW-1 -: 5]),
    .kind_o   (dec_kind),
    .last_o   (dec_last),
    .push_o   (dec_push)
  );

  assign advance = !out_valid_q || out_ready;

`ifdef DE_ISSUE_IRQ_EN
  assign irq_take = irq_req && !reset && (state_q == S_IDLE) && advance && !flush;
`else
  logic irq_req_unused;
  assign irq_req_unused = irq_req;
  assign irq_take       = 1'b0;
`endif

  assign in_ready = !reset && (state_q == S_IDLE) && advance && !flush && !irq_take;

  // Single output register; a stalled micro-op (valid && !ready) is simply not touched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      out_kind_q  <= 3'd0;
      out_slot_q  <= 2'd0;
      out_push_q  <= 1'b0;
      irq_ack_q   <= 1'b0;
    end else begin
      irq_ack_q <= irq_take;
      if (flush) begin
        out_valid_q <= 1'b0;
        state_q     <= S_IDLE;
      end else if (advance) begin
        case (state_q)
          S_IDLE: begin
            if (irq_take) begin
              // Interrupt entry carries no instruction; the PC is the return point.
              out_valid_q <= 1'b1;
              out_instr_q <= '0;
              out_pc_q    <= in_pc;
              out_kind_q  <= K_INT;
              out_slot_q  <= 2'd0;
              out_push_q  <= 1'b1;
              state_q     <= S_SEQ;
            end else if (in_valid) begin
              out_valid_q <= 1'b1;
              out_instr_q <= in_instr;
              out_pc_q    <= in_pc;
              out_kind_q  <= dec_kind;
              out_slot_q  <= 2'd0;
              out_push_q  <= dec_push;
              state_q     <= (dec_last == 2'd0) ? S_IDLE : S_SEQ;
            end else begin
              out_valid_q <= 1'b0;
            end
          end
          S_SEQ: begin
            if (out_slot_q >= last_slot(out_kind_q)) begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              out_slot_q  <= out_slot_q + 2'd1;
            end
          end
          default: begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_kind  = out_kind_q;
  assign out_slot  = out_slot_q;
  assign out_push  = out_push_q;
  assign irq_ack   = irq_ack_q;

endmodule

// File: tb/tb_de_issue_ctrl.sv
// Self-checking bench for de_issue_ctrl: vector table plus hand sequences, scoreboard of expected micro-ops.
module tb_de_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_kind;
  logic [1:0]  out_slot;
  logic        out_push;
  logic        flush;
  logic        irq_req;
  logic        irq_ack;

  de_issue_ctrl #(.IW(16), .PCW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_kind  (out_kind),
    .out_slot  (out_slot),
    .out_push  (out_push),
    .flush     (flush),
    .irq_req   (irq_req),
    .irq_ack   (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
    logic [2:0]  kind;
    logic [1:0]  slot;
    logic        push;
  } uop_t;

  typedef struct {
    logic [15:0] instr;
    logic [31:0] pc;
    logic [2:0]  kind;
    int          n;
    logic        push;
  } vec_t;

  uop_t exp_q[$];
  uop_t mon_act;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[7];
  bit   seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented micro-op must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      mon_act = '{out_instr, out_pc, out_kind, out_slot, out_push};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", mon_act);
      end else begin
        chk("sb_uop", 64'(mon_act), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] ins, input logic [31:0] pc,
                      input logic [2:0] kind, input int n, input logic push);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        for (int s = 0; s < n; s++) exp_q.push_back('{ins, pc, kind, 2'(s), push});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 32'h0;
    out_ready = 1'b1; flush = 1'b0; irq_req = 1'b0;
    idle_cycles(2);
    chk("rst_outs", {out_valid, out_instr, out_pc, out_kind, out_slot, out_push, irq_ack}, 64'd0);
    chk("rst_in_ready", in_ready, 64'd0);
    reset = 1'b0;

    vecs[0] = '{16'h0800, 32'h0000_0100, 3'd0, 1, 1'b0};
    vecs[1] = '{16'hC000, 32'h0000_0200, 3'd1, 2, 1'b1};
    vecs[2] = '{16'hC800, 32'h0000_0300, 3'd2, 2, 1'b0};
    vecs[3] = '{16'hD000, 32'h0000_0304, 3'd3, 3, 1'b0};
    vecs[4] = '{16'hD800, 32'h1234_5678, 3'd0, 1, 1'b0};
    vecs[5] = '{16'hF800, 32'hFFFF_FFFE, 3'd0, 1, 1'b0};
    vecs[6] = '{16'hC7FF, 32'h8000_0000, 3'd1, 2, 1'b1};

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].instr, vecs[v].pc, vecs[v].kind, vecs[v].n, vecs[v].push);
      for (int s = 0; s < vecs[v].n; s++) begin
        @(negedge clk);
        chk("slot_valid", {out_valid, out_kind, out_slot}, {1'b1, vecs[v].kind, 2'(s)});
        chk("seq_in_ready", in_ready, 64'(vecs[v].n == 1));
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("end_valid", out_valid, 64'd0);
      chk("end_in_ready", in_ready, 64'd1);
      @(posedge clk); #1;
    end

    // RTI with slot 1 stalled for three cycles.
    send(16'hD004, 32'hA0A0_0004, 3'd3, 3, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", {out_valid, out_slot}, {1'b1, 2'd1});
      chk("stall_in_ready", in_ready, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("stall_release_s1", {out_valid, out_slot}, {1'b1, 2'd1});
    @(posedge clk); #1;
    @(negedge clk); chk("stall_s2", {out_valid, out_slot}, {1'b1, 2'd2});
    @(posedge clk); #1;
    @(negedge clk); chk("stall_end", out_valid, 64'd0);
    @(posedge clk); #1;

    // Flush during RET slot 0 drops slot 1 and blocks a concurrent offer.
    send(16'hC800, 32'h0000_0400, 3'd2, 2, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h0800; in_pc = 32'h0000_0500;
    @(negedge clk); chk("flush_in_ready", in_ready, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_valid", out_valid, 64'd0);
    chk("flush_idle_ready", in_ready, 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk); chk("flush_idle_block", in_ready, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("flush_idle_valid", out_valid, 64'd0);
    @(posedge clk); #1;

    // Reset while CALL slot 1 is presented.
    send(16'hC000, 32'h0000_0600, 3'd1, 2, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outs", {out_valid, out_instr, out_pc, out_kind, out_slot, out_push, irq_ack}, 64'd0);
    chk("midrst_in_ready", in_ready, 64'd0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk); chk("midrst_after", {out_valid, in_ready}, 64'b01);
    @(posedge clk); #1;

`ifdef DE_ISSUE_IRQ_EN
    // Interrupt wins over a simultaneous offer; the instruction follows the INT sequence.
    irq_req = 1'b1; in_valid = 1'b1; in_instr = 16'hC000; in_pc = 32'h0000_0700;
    for (int s = 0; s < 3; s++) exp_q.push_back('{16'h0000, 32'h0000_0700, 3'd4, 2'(s), 1'b1});
    @(negedge clk); chk("irq_wins", in_ready, 64'd0);
    @(posedge clk); #1;
    irq_req = 1'b0; in_valid = 1'b0;
    chk("irq_ack_pulse", irq_ack, 64'd1);
    @(posedge clk); #1;
    chk("irq_ack_once", irq_ack, 64'd0);
    send(16'hC000, 32'h0000_0700, 3'd1, 2, 1'b1);
    idle_cycles(3);

    // Request raised mid-CALL is deferred until the sequence completes.
    send(16'hC000, 32'h0000_0800, 3'd1, 2, 1'b1);
    in_pc = 32'h0000_0802;
    irq_req = 1'b1;
    for (int s = 0; s < 3; s++) exp_q.push_back('{16'h0000, 32'h0000_0802, 3'd4, 2'(s), 1'b1});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (irq_ack) seen = 1'b1;
    end
    irq_req = 1'b0;
    chk("irq_deferred_ack", 64'(seen), 64'd1);
    idle_cycles(4);
`else
    // Without interrupt support the request is ignored entirely.
    irq_req = 1'b1;
    send(16'h0800, 32'h0000_0900, 3'd0, 1, 1'b0);
    send(16'hC000, 32'h0000_0904, 3'd1, 2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("irq_ack_off", irq_ack, 64'd0);
      @(posedge clk); #1;
    end
    irq_req = 1'b0;
`endif

    idle_cycles(3);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
